// File: rtl/depar_merge_segs_pkg.sv
// Shared definitions for the deparser segment re-assembler.
package depar_merge_segs_pkg;

    typedef enum logic [2:0] {
        WAIT_FST   = 3'd0,
        WAIT_SND   = 3'd1,
        FLUSH_SEGS = 3'd2,
        DROP_SND   = 3'd3,
        DROP_SEGS  = 3'd4
    } state_t;

    localparam int DEFAULT_DROP_BIT = 127;

endpackage

// File: rtl/depar_axis_out_reg.sv
// Registered AXI4-Stream output stage: captures a beat on load, clears on handshake.
module depar_axis_out_reg #(
    parameter int DW = 512,
    parameter int UW = 128
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic            load,
    input  logic [DW-1:0]   in_tdata,
    input  logic [UW-1:0]   in_tuser,
    input  logic [DW/8-1:0] in_tkeep,
    input  logic            in_tlast,
    output logic [DW-1:0]   m_axis_tdata,
    output logic [UW-1:0]   m_axis_tuser,
    output logic [DW/8-1:0] m_axis_tkeep,
    output logic            m_axis_tlast,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready
);

    // Fields are zeroed once consumed so an idle bus never shows stale data.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (load) begin
            m_axis_tdata  <= in_tdata;
            m_axis_tuser  <= in_tuser;
            m_axis_tkeep  <= in_tkeep;
            m_axis_tlast  <= in_tlast;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/depar_merge_segs.sv
// Re-serializes first half, second half and remaining segments into one stream packet.
module depar_merge_segs
    import depar_merge_segs_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_DROP_BIT         = DEFAULT_DROP_BIT
) (
    input  logic                           clk,
    input  logic                           aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]   fst_half_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]  fst_half_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] fst_half_tkeep,
    input  logic                           fst_half_tlast,
    input  logic                           fst_half_empty,
    output logic                           fst_half_rd_en,
    input  logic [C_AXIS_DATA_WIDTH-1:0]   snd_half_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]  snd_half_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] snd_half_tkeep,
    input  logic                           snd_half_tlast,
    input  logic                           snd_half_empty,
    output logic                           snd_half_rd_en,
    input  logic [C_AXIS_DATA_WIDTH-1:0]   seg_fifo_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]  seg_fifo_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] seg_fifo_tkeep,
    input  logic                           seg_fifo_tlast,
    input  logic                           seg_fifo_empty,
    output logic                           seg_fifo_rd_en,
    output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
    output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [31:0]                    pkt_fwd_cnt,
    output logic [31:0]                    pkt_drop_cnt
);

    state_t                           state;
    logic                             can_load;
    logic                             fst_drop;
    logic                             load;
    logic [C_AXIS_DATA_WIDTH-1:0]     sel_tdata;
    logic [C_AXIS_TUSER_WIDTH-1:0]    sel_tuser;
    logic [C_AXIS_DATA_WIDTH/8-1:0]   sel_tkeep;
    logic                             sel_tlast;

    assign can_load = !m_axis_tvalid || m_axis_tready;
    assign fst_drop = fst_half_tuser[C_DROP_BIT];

    // Pops and output load are decided together; dropped beats never reach the output.
    always_comb begin
        fst_half_rd_en = 1'b0;
        snd_half_rd_en = 1'b0;
        seg_fifo_rd_en = 1'b0;
        load           = 1'b0;
        sel_tdata      = fst_half_tdata;
        sel_tuser      = fst_half_tuser;
        sel_tkeep      = fst_half_tkeep;
        sel_tlast      = fst_half_tlast;
        case (state)
            WAIT_FST: begin
                if (!fst_half_empty) begin
                    if (fst_half_tlast) begin
                        if (!snd_half_empty && (can_load || fst_drop)) begin
                            fst_half_rd_en = 1'b1;
                            snd_half_rd_en = 1'b1;
                            load           = !fst_drop;
                        end
                    end else if (can_load || fst_drop) begin
                        fst_half_rd_en = 1'b1;
                        load           = !fst_drop;
                    end
                end
            end
            WAIT_SND: begin
                sel_tdata = snd_half_tdata;
                sel_tuser = snd_half_tuser;
                sel_tkeep = snd_half_tkeep;
                sel_tlast = snd_half_tlast;
                if (!snd_half_empty && can_load) begin
                    snd_half_rd_en = 1'b1;
                    load           = 1'b1;
                end
            end
            FLUSH_SEGS: begin
                sel_tdata = seg_fifo_tdata;
                sel_tuser = seg_fifo_tuser;
                sel_tkeep = seg_fifo_tkeep;
                sel_tlast = seg_fifo_tlast;
                if (!seg_fifo_empty && can_load) begin
                    seg_fifo_rd_en = 1'b1;
                    load           = 1'b1;
                end
            end
            DROP_SND:  snd_half_rd_en = !snd_half_empty;
            DROP_SEGS: seg_fifo_rd_en = !seg_fifo_empty;
            default: ;
        endcase
    end

    // State advances only on a pop, so an empty source simply stalls in place.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= WAIT_FST;
            pkt_fwd_cnt  <= 32'd0;
            pkt_drop_cnt <= 32'd0;
        end else begin
            if (load && sel_tlast)
                pkt_fwd_cnt <= pkt_fwd_cnt + 32'd1;
            case (state)
                WAIT_FST: begin
                    if (fst_half_rd_en) begin
                        if (fst_half_tlast) begin
                            state <= WAIT_FST;
                            if (fst_drop)
                                pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
                        end else begin
                            state <= fst_drop ? DROP_SND : WAIT_SND;
                        end
                    end
                end
                WAIT_SND: begin
                    if (snd_half_rd_en)
                        state <= snd_half_tlast ? WAIT_FST : FLUSH_SEGS;
                end
                FLUSH_SEGS: begin
                    if (seg_fifo_rd_en && seg_fifo_tlast)
                        state <= WAIT_FST;
                end
                DROP_SND: begin
                    if (snd_half_rd_en) begin
                        if (snd_half_tlast) begin
                            state        <= WAIT_FST;
                            pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
                        end else begin
                            state <= DROP_SEGS;
                        end
                    end
                end
                DROP_SEGS: begin
                    if (seg_fifo_rd_en && seg_fifo_tlast) begin
                        state        <= WAIT_FST;
                        pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
                    end
                end
                default: state <= WAIT_FST;
            endcase
        end
    end

    depar_axis_out_reg #(
        .DW(C_AXIS_DATA_WIDTH),
        .UW(C_AXIS_TUSER_WIDTH)
    ) u_out_reg (
        .clk           (clk),
        .aresetn       (aresetn),
        .load          (load),
        .in_tdata      (sel_tdata),
        .in_tuser      (sel_tuser),
        .in_tkeep      (sel_tkeep),
        .in_tlast      (sel_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

endmodule
